// File: rtl/pmem_loader.sv
// rtl/pmem_loader.sv - framed byte stream to 18-bit program-memory word writer
module pmem_loader #(
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 0,
  parameter logic [7:0] SYNC_BYTE = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [17:0]       pmem_wdata,
  output logic              pmem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [31:0] MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_B0,
    S_B1,
    S_B2,
    S_WR,
    S_CKS,
    S_ERR
  } state_t;

  state_t      state, next_state;
  logic [7:0]  len_h;
  logic [15:0] len;
  logic [16:0] count;
  logic [7:0]  sum;
  logic [1:0]  b0_lo;
  logic [7:0]  b1;
  logic        hs;
  logic [15:0] len_n;
  logic        oversize;
  logic        last_word;
  logic [7:0]  sum_n;

  assign hs        = rx_valid && rx_ready;
  assign len_n     = {len_h, rx_data};
  assign oversize  = {16'd0, len_n} > MAX_WORDS;
  assign last_word = (count + 17'd1) == {1'b0, len};
  assign sum_n     = sum + rx_data;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Byte acceptance: blocked only while writing or reporting an error.
  always_comb begin
    rx_ready = 1'b1;
    if (state == S_WR || state == S_ERR) rx_ready = 1'b0;
  end

  // Next-state decode; every byte-driven transition waits for a handshake.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (hs && rx_data == SYNC_BYTE) next_state = S_LEN_H;
      S_LEN_H: if (hs) next_state = S_LEN_L;
      S_LEN_L: begin
        if (hs) begin
          if (oversize)            next_state = S_ERR;
          else if (len_n == 16'd0) next_state = S_CKS;
          else                     next_state = S_B0;
        end
      end
      S_B0: begin
        if (hs) begin
          if (rx_data[7:2] != 6'd0) next_state = S_ERR;
          else                      next_state = S_B1;
        end
      end
      S_B1:    if (hs) next_state = S_B2;
      S_B2:    if (hs) next_state = S_WR;
      S_WR:    next_state = last_word ? S_CKS : S_B0;
      S_CKS:   if (hs) next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: length, checksum, word assembly, write strobe and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_h      <= 8'd0;
      len        <= 16'd0;
      count      <= 17'd0;
      sum        <= 8'd0;
      b0_lo      <= 2'd0;
      b1         <= 8'd0;
      pmem_addr  <= BASE;
      pmem_wdata <= 18'd0;
      pmem_we    <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      pmem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs && rx_data == SYNC_BYTE) begin
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            sum       <= 8'd0;
            count     <= 17'd0;
            pmem_addr <= BASE;
          end
        end
        S_LEN_H: begin
          if (hs) begin
            len_h <= rx_data;
            sum   <= sum_n;
          end
        end
        S_LEN_L: begin
          if (hs) begin
            len <= len_n;
            sum <= sum_n;
          end
        end
        S_B0: begin
          if (hs) begin
            b0_lo <= rx_data[1:0];
            sum   <= sum_n;
          end
        end
        S_B1: begin
          if (hs) begin
            b1  <= rx_data;
            sum <= sum_n;
          end
        end
        S_B2: begin
          if (hs) begin
            pmem_wdata <= {b0_lo, b1, rx_data};
            pmem_we    <= 1'b1;
            sum        <= sum_n;
          end
        end
        S_WR: begin
          // The strobe is live this cycle at the current address; step afterwards.
          pmem_addr <= pmem_addr + ADDR_W'(1);
          count     <= count + 17'd1;
        end
        S_CKS: begin
          if (hs) begin
            if (sum_n == 8'd0) done  <= 1'b1;
            else               error <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        S_ERR: begin
          error    <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
